// File: rtl/ss_display_scanner.sv
// Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
// One nibble at a time goes to a shared decoder; the value is double-buffered and applied at frame wrap.
module ss_display_scanner #(
    parameter int N_DIGITS     = 8,
    parameter int TICK_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic                  value_load,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  blank_lz,
    output logic [3:0]            bcd_out,
    output logic                  seg_blank,
    output logic [N_DIGITS-1:0]   an,
    output logic [2:0]            digit_idx,
    output logic                  frame_done,
    output logic                  load_pending
);
    localparam int CW = $clog2(TICK_CYCLES);
    localparam int DW = 4 * N_DIGITS;
    localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_CYCLES - 1);
    localparam logic [CW-1:0] CNT_DRIVE = CW'(BLANK_CYCLES);
    localparam logic [2:0]    IDX_LAST  = 3'(N_DIGITS - 1);

    logic [CW-1:0]       cnt, cnt_nxt;
    logic [2:0]          idx, idx_nxt;
    logic [DW-1:0]       active, active_nxt;
    logic [DW-1:0]       shadow, shadow_nxt;
    logic                pend_nxt;
    logic [N_DIGITS-1:0] en_q;
    logic                blz_q;
    logic                cnt_last, wrap;
    logic [3:0]          nib;
    logic                en_bit, lz_sup, tail_zero, drive;
    logic [N_DIGITS-1:0] an_nxt;

    // Outputs are decoded from next-state values so they stay aligned with cnt/idx/active;
    // value_load is a single-cycle strobe with no back-pressure.
    always_comb begin
        cnt_last = (cnt == CNT_LAST);
        wrap     = cnt_last && (idx == IDX_LAST);
        cnt_nxt  = cnt_last ? '0 : cnt + CW'(1);
        idx_nxt  = idx;
        if (cnt_last) idx_nxt = wrap ? 3'd0 : idx + 3'd1;

        shadow_nxt = shadow;
        active_nxt = active;
        pend_nxt   = load_pending;
        if (value_load) begin
            shadow_nxt = value_in;
            pend_nxt   = 1'b1;
        end
        if (wrap) begin
            if (value_load) begin
                active_nxt = value_in;
                pend_nxt   = 1'b0;
            end else if (load_pending) begin
                active_nxt = shadow;
                pend_nxt   = 1'b0;
            end
        end

        // Walk from the top digit down so tail_zero means "this digit and all above are 0".
        nib       = 4'd0;
        en_bit    = 1'b0;
        lz_sup    = 1'b0;
        tail_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            tail_zero = tail_zero && (active_nxt[4*i +: 4] == 4'd0);
            if (idx_nxt == 3'(i)) begin
                nib    = active_nxt[4*i +: 4];
                en_bit = en_q[i];
                lz_sup = blz_q && tail_zero && (i != 0);
            end
        end

        drive  = (cnt_nxt >= CNT_DRIVE) && en_bit && !lz_sup;
        an_nxt = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (drive && (idx_nxt == 3'(i))) an_nxt[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= 3'd0;
            active       <= '0;
            shadow       <= '0;
            load_pending <= 1'b0;
            en_q         <= '0;
            blz_q        <= 1'b0;
            an           <= '1;
            bcd_out      <= 4'd0;
            seg_blank    <= 1'b1;
            digit_idx    <= 3'd0;
            frame_done   <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            idx          <= idx_nxt;
            active       <= active_nxt;
            shadow       <= shadow_nxt;
            load_pending <= pend_nxt;
            en_q         <= digit_en;
            blz_q        <= blank_lz;
            an           <= an_nxt;
            bcd_out      <= nib;
            seg_blank    <= !drive;
            digit_idx    <= idx_nxt;
            frame_done   <= wrap;
        end
    end
endmodule

// File: tb/tb_ss_display_scanner.sv
// Bench for ss_display_scanner: 4 digits, 8-cycle slots, 2 blanking cycles.
// Each finished slot is summarised into a record and compared against a queue of expected records.
module tb_ss_display_scanner;
    localparam int REC_W = 23;

    logic        clk;
    logic        rst;
    logic [15:0] value_in;
    logic        value_load;
    logic [3:0]  digit_en;
    logic        blank_lz;
    logic [3:0]  bcd_out;
    logic        seg_blank;
    logic [3:0]  an;
    logic [2:0]  digit_idx;
    logic        frame_done;
    logic        load_pending;

    ss_display_scanner #(
        .N_DIGITS(4),
        .TICK_CYCLES(8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .value_in(value_in),
        .value_load(value_load),
        .digit_en(digit_en),
        .blank_lz(blank_lz),
        .bcd_out(bcd_out),
        .seg_blank(seg_blank),
        .an(an),
        .digit_idx(digit_idx),
        .frame_done(frame_done),
        .load_pending(load_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [REC_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Record fields: idx, bcd, an while driven, drive cycles, slot length, frame_done at start, load_pending at end, anomaly flag.
    function automatic logic [REC_W-1:0] mk_rec(input logic [2:0] idx, input logic [3:0] bcd,
                                                input logic [3:0] anp, input logic [3:0] drv,
                                                input logic [4:0] len, input logic fd,
                                                input logic lp, input logic bad);
        return {idx, bcd, anp, drv, len, fd, lp, bad};
    endfunction

    task automatic exp_slot(input int idx, input logic [3:0] bcd, input logic on,
                            input logic fd, input logic lp);
        logic [3:0] anp;
        anp = on ? ~(4'b0001 << idx) : 4'hF;
        exp_q.push_back(mk_rec(3'(idx), bcd, anp, on ? 4'd6 : 4'd0, 5'd8, fd, lp, 1'b0));
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic sync_frame();
        int k;
        k = 0;
        @(negedge clk);
        while (!frame_done && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (frame_done) n_pass++;
        else $display("FAIL frame_sync: got no frame_done within %0d cycles expected a pulse", k);
        @(posedge clk);
    endtask

    // Monitor state
    logic       in_slot = 1'b0;
    logic [2:0] m_idx;
    logic [3:0] m_bcd, m_anp;
    int         m_drv, m_len;
    logic       m_fd, m_lp, m_bad;

    task automatic close_slot();
        logic [REC_W-1:0] got, exp;
        got = mk_rec(m_idx, m_bcd, m_anp, 4'(m_drv), 5'(m_len), m_fd, m_lp, m_bad);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (got === exp) n_pass++;
            else $display("FAIL slot_rec idx%0d: got %h expected %h (idx,bcd,an,drv,len,fd,lp,bad)",
                          m_idx, got, exp);
        end
        in_slot = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            in_slot = 1'b0;
        end else begin
            if (in_slot && digit_idx != m_idx) close_slot();
            if (!in_slot) begin
                in_slot = 1'b1;
                m_idx   = digit_idx;
                m_bcd   = bcd_out;
                m_anp   = 4'hF;
                m_drv   = 0;
                m_len   = 0;
                m_fd    = frame_done;
                m_bad   = 1'b0;
            end else if (frame_done) begin
                m_bad = 1'b1;
            end
            m_len++;
            if (bcd_out != m_bcd) m_bad = 1'b1;
            if (seg_blank != (an == 4'hF)) m_bad = 1'b1;
            if ($countones(~an) > 1) m_bad = 1'b1;
            if (an != 4'hF) begin
                if (m_drv != 0 && an != m_anp) m_bad = 1'b1;
                m_anp = an;
                m_drv++;
            end
            m_lp = load_pending;
        end
    end

    task automatic pulse_load(input logic [15:0] v);
        value_in   = v;
        value_load = 1'b1;
        @(negedge clk);
        value_load = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        value_in   = 16'h0;
        value_load = 1'b0;
        digit_en   = 4'hF;
        blank_lz   = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg_blank", 32'(seg_blank), 32'd1);
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_digit_idx", 32'(digit_idx), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_load_pending", 32'(load_pending), 32'd0);

        // First frame shows 0 while 1234 waits in the shadow.
        for (int i = 0; i < 4; i++) exp_slot(i, 4'h0, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        value_in   = 16'h1234;
        value_load = 1'b1;
        @(posedge clk);
        #1 value_load = 1'b0;

        // 1234 frame; load 0050 with leading-zero blanking in slot 1.
        sync_frame();
        exp_slot(0, 4'h4, 1'b1, 1'b1, 1'b0);
        exp_slot(1, 4'h3, 1'b1, 1'b0, 1'b1);
        exp_slot(2, 4'h2, 1'b1, 1'b0, 1'b1);
        exp_slot(3, 4'h1, 1'b1, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        blank_lz = 1'b1;
        pulse_load(16'h0050);
        check("lp_after_0050", 32'(load_pending), 32'd1);

        // 0050 with lz blanking: slots 2,3 dark; load 0000.
        sync_frame();
        exp_slot(0, 4'h0, 1'b1, 1'b1, 1'b0);
        exp_slot(1, 4'h5, 1'b1, 1'b0, 1'b1);
        exp_slot(2, 4'h0, 1'b0, 1'b0, 1'b1);
        exp_slot(3, 4'h0, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        pulse_load(16'h0000);

        // Zero with lz blanking: only slot 0 lit; load 5678.
        sync_frame();
        exp_slot(0, 4'h0, 1'b1, 1'b1, 1'b0);
        exp_slot(1, 4'h0, 1'b0, 1'b0, 1'b1);
        exp_slot(2, 4'h0, 1'b0, 1'b0, 1'b1);
        exp_slot(3, 4'h0, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        pulse_load(16'h5678);

        // Unchecked frame used to change controls cleanly.
        sync_frame();
        blank_lz = 1'b0;
        digit_en = 4'b1011;

        // 5678 with digit 2 disabled; AAAA then BBBB loaded mid-frame.
        sync_frame();
        exp_slot(0, 4'h8, 1'b1, 1'b1, 1'b1);
        exp_slot(1, 4'h7, 1'b1, 1'b0, 1'b1);
        exp_slot(2, 4'h6, 1'b0, 1'b0, 1'b1);
        exp_slot(3, 4'h5, 1'b1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        pulse_load(16'hAAAA);
        check("lp_after_aaaa", 32'(load_pending), 32'd1);
        repeat (14) @(negedge clk);
        pulse_load(16'hBBBB);
        check("lp_after_bbbb", 32'(load_pending), 32'd1);
        repeat (7) @(negedge clk);
        digit_en = 4'hF;

        // BBBB frame; a load lands in the wrap cycle itself.
        sync_frame();
        for (int i = 0; i < 4; i++) exp_slot(i, 4'hB, 1'b1, (i == 0), 1'b0);
        repeat (31) @(negedge clk);
        pulse_load(16'hC5DE);
        check("wrap_load_frame_done", 32'(frame_done), 32'd1);
        check("wrap_load_lp", 32'(load_pending), 32'd0);
        @(posedge clk);
        exp_slot(0, 4'hE, 1'b1, 1'b1, 1'b0);
        exp_slot(1, 4'hD, 1'b1, 1'b0, 1'b0);
        exp_slot(2, 4'h5, 1'b1, 1'b0, 1'b0);
        exp_slot(3, 4'hC, 1'b1, 1'b0, 1'b0);

        // Next frame: async reset in the drive phase of slot 2 with a load pending.
        sync_frame();
        repeat (18) @(negedge clk);
        pulse_load(16'h1111);
        @(negedge clk);
        check("pre_rst_lp", 32'(load_pending), 32'd1);
        check("pre_rst_an", 32'(an), 32'b1011);
        check("pre_rst_bcd", 32'(bcd_out), 32'h5);
        #2 rst = 1'b1;
        #1;
        check("async_rst_an", 32'(an), 32'hF);
        check("async_rst_seg_blank", 32'(seg_blank), 32'd1);
        check("async_rst_idx", 32'(digit_idx), 32'd0);
        check("async_rst_bcd", 32'(bcd_out), 32'd0);
        check("async_rst_lp", 32'(load_pending), 32'd0);
        for (int i = 0; i < 4; i++) exp_slot(i, 4'h0, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        sync_frame();
        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ss_display_scanner.md
Name: ss_display_scanner

Overview:
- Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
- Shares a single hex-to-seven-segment decoder across all digits by presenting one 4-bit nibble at a time on bcd_out and driving the matching active-low anode.
- Double-buffers the displayed value so updates appear only at frame boundaries.
- Inserts a ghost-suppression blanking interval at the start of every digit slot and supports leading-zero blanking.

Parameters:
- N_DIGITS, 8, number of digits scanned; legal range 2..8.
- TICK_CYCLES, 100000, clk cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 2000, cycles at the start of each slot with all anodes off; must satisfy 1 <= BLANK_CYCLES < TICK_CYCLES.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- value_in  input  4*N_DIGITS  nibble i is bits [4i+3:4i]; digit 0 is least significant.
- value_load  input  1  one-cycle strobe that captures value_in into the shadow register.
- digit_en  input  N_DIGITS  per-digit enable; 0 keeps that anode off for its slot.
- blank_lz  input  1  1 enables leading-zero blanking.
- bcd_out  output  4  nibble for the current digit; goes to the shared decoder.
- seg_blank  output  1  1 means segments must be forced off; the top level ORs it into the decoder output.
- an  output  N_DIGITS  active-low anodes; at most one bit is 0 at any time.
- digit_idx  output  3  current slot index.
- frame_done  output  1  one-cycle pulse at each frame wrap.
- load_pending  output  1  shadow holds a value not yet applied.

Behaviour:
- Reset (asynchronous, active-high, applied immediately regardless of clk):
  - cnt=0, idx=0, active=0, shadow=0, load_pending=0.
  - Registered copies of digit_en and blank_lz = 0.
  - an=all 1, bcd_out=0, seg_blank=1, digit_idx=0, frame_done=0.
  - After rst deasserts, scanning starts at slot 0 in its blanking phase.
- Registers:
  - cnt runs 0..TICK_CYCLES-1.
  - idx runs 0..N_DIGITS-1.
  - digit_en and blank_lz are registered every cycle; a change takes effect on outputs 1 cycle later.
- Slot timing:
  - cnt < BLANK_CYCLES: blanking phase.
  - cnt >= BLANK_CYCLES: drive phase.
  - At cnt==TICK_CYCLES-1: cnt goes to 0 and idx increments, wrapping from N_DIGITS-1 to 0.
- Outputs are registered and decode the current cnt/idx/active/en registers. There is no combinational path from any input to any output.
- bcd_out = active nibble[idx] at all times, including the blanking phase, so the decoder output settles before the anode turns on.
- Digit idx is suppressed when any of the following holds:
  - the registered digit_en[idx] = 0;
  - the registered blank_lz = 1, idx > 0, and active nibbles idx..N_DIGITS-1 are all 0.
  - Digit 0 is never lz-suppressed, so the value 0 shows a single "0".
- an[idx]=0 only during the drive phase of a non-suppressed digit; otherwise an is all 1.
- seg_blank = 1 whenever no anode is low.
- A suppressed or disabled slot still consumes the full TICK_CYCLES; the frame period is fixed at N_DIGITS*TICK_CYCLES.
- Double buffer:
  - value_load=1 copies value_in into shadow and sets load_pending. A later load before the wrap overwrites the shadow (latest value wins).
  - On the wrap edge (idx N_DIGITS-1 to 0), if load_pending: active <= shadow and load_pending <= 0.
  - If value_load is asserted in that same wrap cycle: active <= value_in directly, shadow <= value_in, load_pending <= 0.
- frame_done is 1 for exactly the cycle after the wrap edge, i.e. while idx==0 and cnt==0.
- digit_idx mirrors idx.

Test Plan:
- N_DIGITS=4, TICK_CYCLES=8, BLANK_CYCLES=2. Release rst and load 16'h1234 with value_load at cycle 0:
  - first frame shows 0;
  - the new value appears after the wrap, with bcd_out=4,3,2,1 on slots 0..3;
  - an is 1110/1101/1011/0111 for 6 cycles each, all-1 for 2 cycles between;
  - frame_done pulses every 32 cycles.
- blank_lz=1 with value 16'h0050:
  - slots 2 and 3 keep an all-1 and seg_blank=1;
  - slots 0 and 1 are driven.
- blank_lz=1 with value 0:
  - only slot 0 is driven, with bcd_out=0.
- digit_en=4'b1011:
  - slot 2 is never driven;
  - frame length stays 32 cycles.
- Loads of 16'hAAAA then 16'hBBBB mid-frame:
  - load_pending=1 until the wrap;
  - the next frame shows B on every slot.
- A load coinciding with the wrap cycle:
  - the value shows in the immediately following frame and load_pending stays 0.
- Assert rst mid-slot 2 during the drive phase:
  - an goes to all 1, seg_blank=1, idx=0 and active=0 immediately, without waiting for clk;
  - scanning restarts from slot 0 in its blanking phase.
